// File: rtl/hrtimer_avalon_driver_if.sv
// Avalon-MM link between hrtimer_avalon_driver (master) and the interval timer s1 port (slave).
interface hrtimer_avalon_driver_if;
    logic [2:0]  av_address;
    logic        av_chipselect;
    logic        av_write_n;
    logic [15:0] av_writedata;
    logic [15:0] av_readdata;
    logic        av_irq;

    modport master (
        output av_address,
        output av_chipselect,
        output av_write_n,
        output av_writedata,
        input  av_readdata,
        input  av_irq
    );

    modport slave (
        input  av_address,
        input  av_chipselect,
        input  av_write_n,
        input  av_writedata,
        output av_readdata,
        output av_irq
    );
endinterface

// File: rtl/hrtimer_avalon_driver.sv
// Autonomous Avalon-MM master that programs, services and snapshots the 16-bit-register
// interval timer; every non-wait state is exactly one registered bus cycle.
module hrtimer_avalon_driver #(
    parameter int READ_LATENCY = 1,
    parameter int TICK_CNT_W   = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cmd_start,
    input  logic [31:0]           cmd_period,
    input  logic                  cmd_continuous,
    input  logic                  cmd_stop,
    input  logic                  snap_req,
    output logic                  cmd_ready,
    hrtimer_avalon_driver_if.master av,
    output logic                  running,
    output logic                  tick,
    output logic [TICK_CNT_W-1:0] tick_count,
    output logic                  snap_valid,
    output logic [31:0]           snap_value
);

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_WR_PL    = 4'd1;
    localparam logic [3:0] ST_WR_PH    = 4'd2;
    localparam logic [3:0] ST_WR_START = 4'd3;
    localparam logic [3:0] ST_RUN      = 4'd4;
    localparam logic [3:0] ST_CLR      = 4'd5;
    localparam logic [3:0] ST_TICK     = 4'd6;
    localparam logic [3:0] ST_WR_STOP  = 4'd7;
    localparam logic [3:0] ST_CLR_STOP = 4'd8;
    localparam logic [3:0] ST_SNAP_WR  = 4'd9;
    localparam logic [3:0] ST_RD_L     = 4'd10;
    localparam logic [3:0] ST_WAIT_L   = 4'd11;
    localparam logic [3:0] ST_RD_H     = 4'd12;
    localparam logic [3:0] ST_WAIT_H   = 4'd13;

    localparam logic [1:0]            WAIT_INIT = 2'(READ_LATENCY - 1);
    localparam logic [TICK_CNT_W-1:0] CNT_ONE   = TICK_CNT_W'(1);

    logic [3:0]            state_r;
    logic [3:0]            state_nxt_s;
    logic [31:0]           period_r;
    logic [31:0]           period_nxt_s;
    logic                  cont_r;
    logic                  cont_nxt_s;
    logic                  start_acc_s;
    logic [1:0]            wait_cnt_r;
    logic                  wait_done_s;
    logic [15:0]           snap_lo_r;

    logic                  bus_cs_s;
    logic                  bus_wr_n_s;
    logic [2:0]            bus_addr_s;
    logic [15:0]           bus_wdata_s;
    logic                  av_cs_r;
    logic                  av_wr_n_r;
    logic [2:0]            av_addr_r;
    logic [15:0]           av_wdata_r;

    logic                  cmd_ready_r;
    logic                  running_r;
    logic                  tick_r;
    logic [TICK_CNT_W-1:0] tick_count_r;
    logic                  snap_valid_r;
    logic [31:0]           snap_value_r;

    assign start_acc_s  = (state_r == ST_IDLE) && cmd_start;
    assign period_nxt_s = start_acc_s ? cmd_period : period_r;
    assign cont_nxt_s   = start_acc_s ? cmd_continuous : cont_r;
    assign wait_done_s  = (wait_cnt_r == 2'd0);

    // Sequencer next-state: command acceptance, irq service and snapshot reads.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_start) begin
                    state_nxt_s = ST_WR_PL;
                end else if (snap_req) begin
                    state_nxt_s = ST_SNAP_WR;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WR_PL:    state_nxt_s = ST_WR_PH;
            ST_WR_PH:    state_nxt_s = ST_WR_START;
            ST_WR_START: state_nxt_s = ST_RUN;
            ST_RUN: begin
                if (cmd_stop) begin
                    state_nxt_s = ST_WR_STOP;
                end else if (av.av_irq) begin
                    state_nxt_s = ST_CLR;
                end else if (snap_req) begin
                    state_nxt_s = ST_SNAP_WR;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_CLR:      state_nxt_s = ST_TICK;
            ST_TICK:     state_nxt_s = cont_r ? ST_RUN : ST_IDLE;
            ST_WR_STOP:  state_nxt_s = ST_CLR_STOP;
            ST_CLR_STOP: state_nxt_s = ST_IDLE;
            ST_SNAP_WR:  state_nxt_s = ST_RD_L;
            ST_RD_L:     state_nxt_s = ST_WAIT_L;
            ST_WAIT_L:   state_nxt_s = wait_done_s ? ST_RD_H : ST_WAIT_L;
            ST_RD_H:     state_nxt_s = ST_WAIT_H;
            ST_WAIT_H: begin
                if (wait_done_s) begin
                    state_nxt_s = running_r ? ST_RUN : ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT_H;
                end
            end
            default:     state_nxt_s = ST_IDLE;
        endcase
    end

    // Bus cycle for the state being entered, so av_* can be registered alongside the state.
    always_comb begin
        bus_cs_s    = 1'b0;
        bus_wr_n_s  = 1'b1;
        bus_addr_s  = 3'd0;
        bus_wdata_s = 16'h0000;
        case (state_nxt_s)
            ST_WR_PL: begin
                bus_cs_s    = 1'b1;
                bus_wr_n_s  = 1'b0;
                bus_addr_s  = 3'd2;
                bus_wdata_s = period_nxt_s[15:0];
            end
            ST_WR_PH: begin
                bus_cs_s    = 1'b1;
                bus_wr_n_s  = 1'b0;
                bus_addr_s  = 3'd3;
                bus_wdata_s = period_nxt_s[31:16];
            end
            ST_WR_START: begin
                bus_cs_s    = 1'b1;
                bus_wr_n_s  = 1'b0;
                bus_addr_s  = 3'd1;
                bus_wdata_s = {12'h000, 1'b0, 1'b1, cont_nxt_s, 1'b1};
            end
            ST_CLR, ST_CLR_STOP: begin
                bus_cs_s    = 1'b1;
                bus_wr_n_s  = 1'b0;
                bus_addr_s  = 3'd0;
                bus_wdata_s = 16'h0000;
            end
            ST_WR_STOP: begin
                bus_cs_s    = 1'b1;
                bus_wr_n_s  = 1'b0;
                bus_addr_s  = 3'd1;
                bus_wdata_s = 16'h0008;
            end
            ST_SNAP_WR: begin
                bus_cs_s    = 1'b1;
                bus_wr_n_s  = 1'b0;
                bus_addr_s  = 3'd4;
                bus_wdata_s = 16'h0000;
            end
            ST_RD_L: begin
                bus_cs_s    = 1'b1;
                bus_wr_n_s  = 1'b1;
                bus_addr_s  = 3'd4;
                bus_wdata_s = 16'h0000;
            end
            ST_RD_H: begin
                bus_cs_s    = 1'b1;
                bus_wr_n_s  = 1'b1;
                bus_addr_s  = 3'd5;
                bus_wdata_s = 16'h0000;
            end
            default: begin
                bus_cs_s    = 1'b0;
                bus_wr_n_s  = 1'b1;
                bus_addr_s  = 3'd0;
                bus_wdata_s = 16'h0000;
            end
        endcase
    end

    // State, latched command and registered bus outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            period_r    <= 32'h0000_0000;
            cont_r      <= 1'b0;
            av_cs_r     <= 1'b0;
            av_wr_n_r   <= 1'b1;
            av_addr_r   <= 3'd0;
            av_wdata_r  <= 16'h0000;
            cmd_ready_r <= 1'b1;
            wait_cnt_r  <= 2'd0;
        end else begin
            state_r     <= state_nxt_s;
            period_r    <= period_nxt_s;
            cont_r      <= cont_nxt_s;
            av_cs_r     <= bus_cs_s;
            av_wr_n_r   <= bus_wr_n_s;
            av_addr_r   <= bus_addr_s;
            av_wdata_r  <= bus_wdata_s;
            cmd_ready_r <= (state_nxt_s == ST_IDLE);
            if ((state_r == ST_RD_L) || (state_r == ST_RD_H)) begin
                wait_cnt_r <= WAIT_INIT;
            end else if (!wait_done_s) begin
                wait_cnt_r <= wait_cnt_r - 2'd1;
            end else begin
                wait_cnt_r <= wait_cnt_r;
            end
        end
    end

    // Status outputs: running flag, tick pulse/count and snapshot capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            running_r    <= 1'b0;
            tick_r       <= 1'b0;
            tick_count_r <= '0;
            snap_valid_r <= 1'b0;
            snap_value_r <= 32'h0000_0000;
            snap_lo_r    <= 16'h0000;
        end else begin
            tick_r       <= (state_nxt_s == ST_TICK);
            snap_valid_r <= (state_r == ST_WAIT_H) && wait_done_s;
            if (state_r == ST_WR_START) begin
                running_r <= 1'b1;
            end else if (((state_r == ST_TICK) && !cont_r) || (state_r == ST_CLR_STOP)) begin
                running_r <= 1'b0;
            end else begin
                running_r <= running_r;
            end
            if (start_acc_s) begin
                tick_count_r <= '0;
            end else if (state_nxt_s == ST_TICK) begin
                tick_count_r <= tick_count_r + CNT_ONE;
            end else begin
                tick_count_r <= tick_count_r;
            end
            if ((state_r == ST_WAIT_L) && wait_done_s) begin
                snap_lo_r <= av.av_readdata;
            end else begin
                snap_lo_r <= snap_lo_r;
            end
            if ((state_r == ST_WAIT_H) && wait_done_s) begin
                snap_value_r <= {av.av_readdata, snap_lo_r};
            end else begin
                snap_value_r <= snap_value_r;
            end
        end
    end

    assign av.av_chipselect = av_cs_r;
    assign av.av_write_n    = av_wr_n_r;
    assign av.av_address    = av_addr_r;
    assign av.av_writedata  = av_wdata_r;
    assign cmd_ready        = cmd_ready_r;
    assign running          = running_r;
    assign tick             = tick_r;
    assign tick_count       = tick_count_r;
    assign snap_valid       = snap_valid_r;
    assign snap_value       = snap_value_r;

endmodule

// File: tb/tb_hrtimer_avalon_driver.sv
// Randomized bench for hrtimer_avalon_driver: two instances (READ_LATENCY 1 and 2) exercised in turn,
// expected bus traffic and status derived from the command/irq rules by a transaction-level model.
module tb_hrtimer_avalon_driver;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]        start_v = 2'b00;
    logic [1:0]        stop_v  = 2'b00;
    logic [1:0]        snap_v  = 2'b00;
    logic [1:0]        irq_v   = 2'b00;
    logic [31:0]       period  = 32'h0;
    logic              cont    = 1'b0;
    logic [15:0]       snap_l_val = 16'h0;
    logic [15:0]       snap_h_val = 16'h0;
    logic [15:0]       junk_r;

    logic [1:0]        cs_v, wn_v, ready_v, running_v, tick_v, svalid_v;
    logic [1:0][2:0]   addr_v;
    logic [1:0][15:0]  wdata_v;
    logic [1:0][31:0]  cnt_v;
    logic [1:0][31:0]  sval_v;

    int sel = 0;
    int n_checks = 0;
    int n_errors = 0;
    bit running_m = 1'b0;
    bit cont_m = 1'b0;
    logic [31:0] count_m = 32'h0;

    always @(posedge clk) junk_r <= 16'($urandom);

    for (genvar k = 0; k < 2; k++) begin : g_dut
        hrtimer_avalon_driver_if bus ();
        logic [3:0] pv = 4'b0000;
        logic [2:0] pa [4];

        // Timer slave: read data appears exactly k+1 cycles after the read cycle, junk otherwise.
        always @(posedge clk) begin
            pv    <= {pv[2:0], bus.av_chipselect & bus.av_write_n};
            pa[0] <= bus.av_address;
            for (int i = 1; i < 4; i++) pa[i] <= pa[i-1];
        end
        assign bus.av_readdata = !pv[k] ? junk_r :
                                 (pa[k] == 3'd4) ? snap_l_val :
                                 (pa[k] == 3'd5) ? snap_h_val : 16'hDEAD;
        assign bus.av_irq   = irq_v[k];
        assign cs_v[k]      = bus.av_chipselect;
        assign wn_v[k]      = bus.av_write_n;
        assign addr_v[k]    = bus.av_address;
        assign wdata_v[k]   = bus.av_writedata;

        hrtimer_avalon_driver #(.READ_LATENCY(k + 1), .TICK_CNT_W(32)) dut (
            .clk            (clk),
            .reset_n        (reset_n),
            .cmd_start      (start_v[k]),
            .cmd_period     (period),
            .cmd_continuous (cont),
            .cmd_stop       (stop_v[k]),
            .snap_req       (snap_v[k]),
            .cmd_ready      (ready_v[k]),
            .av             (bus),
            .running        (running_v[k]),
            .tick           (tick_v[k]),
            .tick_count     (cnt_v[k]),
            .snap_valid     (svalid_v[k]),
            .snap_value     (sval_v[k])
        );
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s (lat=%0d): got %0h expected %0h", tag, sel + 1, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_bus(input string tag, input logic ecs, input logic ewn,
                           input logic [2:0] ea, input logic [15:0] ed, input logic dchk);
        logic [20:0] obs, exp;
        if (!ecs) begin
            obs = {cs_v[sel], wn_v[sel], 19'd0};
            exp = {1'b0, 1'b1, 19'd0};
        end else if (!dchk) begin
            obs = {cs_v[sel], wn_v[sel], addr_v[sel], 16'd0};
            exp = {1'b1, ewn, ea, 16'd0};
        end else begin
            obs = {cs_v[sel], wn_v[sel], addr_v[sel], wdata_v[sel]};
            exp = {1'b1, ewn, ea, ed};
        end
        check(tag, 64'(obs), 64'(exp));
    endtask

    task automatic chk_reset_vals();
        chk_bus("rst_bus", 1'b0, 1'b1, 3'd0, 16'h0, 1'b0);
        check("rst_addr_data", 64'({addr_v[sel], wdata_v[sel]}), 64'(0));
        check("rst_flags", 64'({running_v[sel], tick_v[sel], svalid_v[sel], ready_v[sel]}), 64'(4'b0001));
        check("rst_cnt_snap", {cnt_v[sel], sval_v[sel]}, 64'(0));
    endtask

    task automatic model_reset();
        running_m = 1'b0;
        cont_m    = 1'b0;
        count_m   = 32'h0;
        irq_v = 2'b00; stop_v = 2'b00; snap_v = 2'b00; start_v = 2'b00;
    endtask

    task automatic do_reset();
        model_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk_reset_vals();
        @(negedge clk);
        reset_n = 1'b1;
        cyc();
        chk_bus("post_rst_idle", 1'b0, 1'b1, 3'd0, 16'h0, 1'b0);
    endtask

    task automatic do_start(input logic [31:0] p, input logic c);
        check("start_ready", 64'(ready_v[sel]), 64'(1));
        period = p; cont = c;
        start_v[sel] = 1'b1;
        cyc();
        start_v[sel] = 1'b0;
        // requests arriving mid-sequence must be dropped
        stop_v[sel] = 1'($urandom); snap_v[sel] = 1'($urandom); start_v[sel] = 1'($urandom);
        chk_bus("wr_pl", 1'b1, 1'b0, 3'd2, p[15:0], 1'b1);
        check("start_cnt_clear", 64'({cnt_v[sel], ready_v[sel]}), 64'(0));
        cyc();
        stop_v[sel] = 1'b0; snap_v[sel] = 1'b0; start_v[sel] = 1'b0;
        chk_bus("wr_ph", 1'b1, 1'b0, 3'd3, p[31:16], 1'b1);
        cyc();
        chk_bus("wr_start", 1'b1, 1'b0, 3'd1, c ? 16'h0007 : 16'h0005, 1'b1);
        check("start_not_running", 64'(running_v[sel]), 64'(0));
        cyc();
        chk_bus("run_idle", 1'b0, 1'b1, 3'd0, 16'h0, 1'b0);
        check("run_running", 64'({running_v[sel], ready_v[sel]}), 64'(2'b10));
        running_m = 1'b1; cont_m = c; count_m = 32'h0;
    endtask

    task automatic do_service();
        irq_v[sel] = 1'b1;
        cyc();
        chk_bus("clr", 1'b1, 1'b0, 3'd0, 16'h0000, 1'b1);
        irq_v[sel] = 1'b0;
        cyc();
        count_m = count_m + 32'd1;
        check("tick_pulse", 64'(tick_v[sel]), 64'(1));
        check("tick_count", 64'(cnt_v[sel]), 64'(count_m));
        chk_bus("tick_idle", 1'b0, 1'b1, 3'd0, 16'h0, 1'b0);
        cyc();
        running_m = cont_m;
        check("after_tick", 64'({tick_v[sel], running_v[sel], ready_v[sel]}),
              64'({1'b0, running_m, ~running_m}));
    endtask

    task automatic do_stop(input logic with_irq);
        stop_v[sel] = 1'b1;
        irq_v[sel]  = with_irq;
        cyc();
        stop_v[sel] = 1'b0;
        chk_bus("wr_stop", 1'b1, 1'b0, 3'd1, 16'h0008, 1'b1);
        cyc();
        chk_bus("clr_stop", 1'b1, 1'b0, 3'd0, 16'h0000, 1'b1);
        irq_v[sel] = 1'b0;
        cyc();
        running_m = 1'b0;
        check("stop_state", 64'({tick_v[sel], running_v[sel], ready_v[sel]}), 64'(3'b001));
        check("stop_count", 64'(cnt_v[sel]), 64'(count_m));
    endtask

    task automatic do_snap(input logic [15:0] lo, input logic [15:0] hi,
                           input logic irq_mid, input logic rst_mid);
        snap_l_val = lo; snap_h_val = hi;
        snap_v[sel] = 1'b1;
        cyc();
        snap_v[sel] = 1'b0;
        chk_bus("snap_wr", 1'b1, 1'b0, 3'd4, 16'h0, 1'b0);
        cyc();
        chk_bus("rd_l", 1'b1, 1'b1, 3'd4, 16'h0, 1'b0);
        if (irq_mid) irq_v[sel] = 1'b1;
        for (int i = 0; i <= sel; i++) begin
            cyc();
            chk_bus("wait_l", 1'b0, 1'b1, 3'd0, 16'h0, 1'b0);
        end
        cyc();
        chk_bus("rd_h", 1'b1, 1'b1, 3'd5, 16'h0, 1'b0);
        if (rst_mid) begin
            reset_n = 1'b0;
            #1;
            chk_reset_vals();
            model_reset();
            @(negedge clk);
            reset_n = 1'b1;
            for (int i = 0; i < 4; i++) begin
                cyc();
                chk_bus("rst_mid_quiet", 1'b0, 1'b1, 3'd0, 16'h0, 1'b0);
                check("rst_mid_ready", 64'(ready_v[sel]), 64'(1));
            end
            return;
        end
        for (int i = 0; i <= sel; i++) begin
            cyc();
            chk_bus("wait_h", 1'b0, 1'b1, 3'd0, 16'h0, 1'b0);
            check("snap_early", 64'(svalid_v[sel]), 64'(0));
        end
        cyc();
        check("snap_valid", 64'(svalid_v[sel]), 64'(1));
        check("snap_value", 64'(sval_v[sel]), 64'({hi, lo}));
        check("snap_return", 64'({running_v[sel], ready_v[sel]}), 64'({running_m, ~running_m}));
        if (irq_mid) begin
            do_service();
        end else begin
            cyc();
            check("snap_pulse_end", 64'(svalid_v[sel]), 64'(0));
        end
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            sel = s;
            do_reset();
            do_start(32'h0001_86A0, 1'b1);
            repeat (3) do_service();
            do_snap(16'h1234, 16'h0005, 1'b0, 1'b0);
            do_stop(1'b1);
            do_start(32'd10, 1'b0);
            do_service();
            do_snap(16'($urandom), 16'($urandom), 1'b0, 1'b0);
            do_start(32'd0, 1'b1);
            do_snap(16'($urandom), 16'($urandom), 1'b1, 1'b0);
            do_stop(1'b0);
            for (int i = 0; i < 30; i++) begin
                automatic int r = $urandom_range(0, 3);
                if (!running_m) begin
                    if (r < 3) do_start($urandom, 1'($urandom));
                    else do_snap(16'($urandom), 16'($urandom), 1'b0, 1'b0);
                end else begin
                    case (r)
                        0: do_service();
                        1: do_stop(1'($urandom));
                        2: do_snap(16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
                        default: do_service();
                    endcase
                end
            end
            if (running_m) do_stop(1'b0);
            do_start($urandom, 1'b1);
            do_snap(16'($urandom), 16'($urandom), 1'b0, 1'b1);
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
